// File: rtl/mpsoc_dbg_pkg.sv
// ---------------------------------------------------------------------------
// mpsoc_dbg_pkg
// Shared definitions for the OR1K debug burst sequencer.
//   burst_state_t   : sequencer FSM states
//   BURST_CMD_READ  : cmd_wr_i value selecting a read burst
//   BURST_CMD_WRITE : cmd_wr_i value selecting a write burst
// ---------------------------------------------------------------------------
package mpsoc_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WFETCH = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RPUSH  = 3'd4
  } burst_state_t;

  localparam logic BURST_CMD_READ  = 1'b0;
  localparam logic BURST_CMD_WRITE = 1'b1;

endpackage

// File: rtl/mpsoc_dbg_or1k_burst_seq.sv
// ---------------------------------------------------------------------------
// mpsoc_dbg_or1k_burst_seq
// TCK-domain burst sequencer in front of the OR1K debug BIU. One burst
// command becomes a series of single-word strobe/ready accesses; write data
// is pulled from a valid/ready stream, read data pushed to one, and the
// address advances by ADDR_INC after every completed word.
//
// Ports:
//   tck_i, tlr_i                  clock, async active-high reset
//   cmd_valid_i/cmd_ready_o       command handshake (wr, addr, count, sel)
//   abort_i                       abort the running burst
//   wdata_valid_i/wdata_ready_o   write-data stream (wdata_i)
//   rdata_valid_o/rdata_ready_i   read-data stream (rdata_o)
//   biu_*                         single-word BIU request/response
//   busy_o, done_o, aborted_o     burst status
//   words_done_o                  words completed in current/last burst
// ---------------------------------------------------------------------------
module mpsoc_dbg_or1k_burst_seq
  import mpsoc_dbg_pkg::*;
#(
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int ADDR_INC       = 4
) (
  input  logic                      tck_i,
  input  logic                      tlr_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_wr_i,
  input  logic [CPU_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [CNT_WIDTH-1:0]      cmd_count_i,
  input  logic [3:0]                cmd_sel_i,
  input  logic                      abort_i,
  input  logic                      wdata_valid_i,
  output logic                      wdata_ready_o,
  input  logic [CPU_DATA_WIDTH-1:0] wdata_i,
  output logic                      rdata_valid_o,
  input  logic                      rdata_ready_i,
  output logic [CPU_DATA_WIDTH-1:0] rdata_o,
  output logic [3:0]                biu_sel_o,
  output logic                      biu_strobe_o,
  output logic                      biu_rd_wrn_o,
  output logic [CPU_ADDR_WIDTH-1:0] biu_addr_o,
  output logic [CPU_DATA_WIDTH-1:0] biu_data_o,
  input  logic [CPU_DATA_WIDTH-1:0] biu_data_i,
  input  logic                      biu_rdy_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o,
  output logic [CNT_WIDTH-1:0]      words_done_o
);

  burst_state_t         state, next_state;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 abort_pend;

  logic accept, finish, abort_end, wtake, biu_complete;

  // Handshake outputs are pure state decodes, so nothing combinationally
  // depends on an input.
  assign cmd_ready_o   = (state == ST_IDLE);
  assign wdata_ready_o = (state == ST_WFETCH);
  assign biu_strobe_o  = (state == ST_ISSUE);
  assign rdata_valid_o = (state == ST_RPUSH);
  assign busy_o        = (state != ST_IDLE);

  // State register; tlr_i drops any burst immediately since the BIU is
  // reset by the same signal.
  always_ff @(posedge tck_i or posedge tlr_i) begin
    if (tlr_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and event decode. A completing handshake always wins over a
  // simultaneous abort; an abort seen while an access is in flight is held
  // in abort_pend until that access completes.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    finish       = 1'b0;
    abort_end    = 1'b0;
    wtake        = 1'b0;
    biu_complete = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept = 1'b1;
          if (cmd_count_i == '0)                 finish     = 1'b1;
          else if (cmd_wr_i == BURST_CMD_WRITE)  next_state = ST_WFETCH;
          else                                   next_state = ST_ISSUE;
        end
      end
      ST_WFETCH: begin
        if (wdata_valid_i) begin
          wtake      = 1'b1;
          next_state = ST_ISSUE;
        end else if (abort_i) begin
          next_state = ST_IDLE;
          finish     = 1'b1;
          abort_end  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (biu_rdy_i) begin
          next_state = ST_WAIT;
        end else if (abort_i) begin
          next_state = ST_IDLE;
          finish     = 1'b1;
          abort_end  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (biu_rdy_i) begin
          biu_complete = 1'b1;
          if (abort_pend || abort_i) begin
            next_state = ST_IDLE;
            finish     = 1'b1;
            abort_end  = 1'b1;
          end else if (biu_rd_wrn_o) begin
            next_state = ST_RPUSH;
          end else if (remaining == CNT_WIDTH'(1)) begin
            next_state = ST_IDLE;
            finish     = 1'b1;
          end else begin
            next_state = ST_WFETCH;
          end
        end
      end
      ST_RPUSH: begin
        if (rdata_ready_i) begin
          if (remaining == '0) begin
            next_state = ST_IDLE;
            finish     = 1'b1;
          end else begin
            next_state = ST_ISSUE;
          end
        end else if (abort_i) begin
          next_state = ST_IDLE;
          finish     = 1'b1;
          abort_end  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address/count datapath and registered status. remaining is decremented
  // on completion, so WAIT compares against 1 and RPUSH against 0.
  always_ff @(posedge tck_i or posedge tlr_i) begin
    if (tlr_i) begin
      remaining    <= '0;
      abort_pend   <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      words_done_o <= '0;
      biu_rd_wrn_o <= 1'b1;
      biu_addr_o   <= '0;
      biu_data_o   <= '0;
      biu_sel_o    <= '0;
      rdata_o      <= '0;
    end else begin
      done_o <= finish;
      if (accept) begin
        remaining    <= cmd_count_i;
        words_done_o <= '0;
        aborted_o    <= 1'b0;
        biu_rd_wrn_o <= (cmd_wr_i != BURST_CMD_WRITE);
        biu_addr_o   <= cmd_addr_i;
        biu_sel_o    <= cmd_sel_i;
      end
      if (abort_end) aborted_o <= 1'b1;
      if (wtake)     biu_data_o <= wdata_i;
      if (biu_complete) begin
        words_done_o <= words_done_o + CNT_WIDTH'(1);
        remaining    <= remaining - CNT_WIDTH'(1);
        biu_addr_o   <= biu_addr_o + CPU_ADDR_WIDTH'(ADDR_INC);
        if (next_state == ST_RPUSH) rdata_o <= biu_data_i;
      end
      unique case (state)
        ST_ISSUE: abort_pend <= abort_i & biu_rdy_i;
        ST_WAIT:  abort_pend <= abort_pend | abort_i;
        default:  abort_pend <= 1'b0;
      endcase
    end
  end

endmodule
